// File: rtl/ddr_port_pkg.sv
// Shared types and constants for the Wishbone-to-DDR read-buffered port.
package ddr_port_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } port_state_e;

    function automatic int line_words(input int buf_width);
        return 1 << buf_width;
    endfunction

endpackage

// File: rtl/ddr_line_buf.sv
// One-line read buffer: byte-enabled synchronous write port, asynchronous read port.
module ddr_line_buf
    import ddr_port_pkg::*;
#(
    parameter int BUF_WIDTH = 3,
    parameter int IDX_W     = 3
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WB_SELW-1:0] wr_sel,
    input  logic [WB_DW-1:0]   wr_dat,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [WB_DW-1:0]   rd_dat
);

    localparam int LINE_WORDS = line_words(BUF_WIDTH);

    logic [WB_DW-1:0] mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < WB_SELW; b++) begin
                if (wr_sel[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/wb_ddr_rd_buf_port.sv
// Wishbone classic slave in front of the DDR controller wrapper: reads are served
// from a one-line buffer filled by bursts, writes pass through and merge into it.
module wb_ddr_rd_buf_port
    import ddr_port_pkg::*;
#(
    parameter int BUF_WIDTH  = 3,
    parameter int ADDR_WIDTH = 25
) (
    input  logic               local_clk_i,
    input  logic               local_reset_n_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    input  logic [WB_SELW-1:0] wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic               wb_ack_o,
    output logic               acc_o,
    output logic               we_o,
    output logic [31:0]        adr_o,
    output logic [WB_DW-1:0]   dat_o,
    output logic [WB_SELW-1:0] sel_o,
    output logic [3:0]         buf_width_o,
    input  logic               rdy_i,
    input  logic               idle_i,
    input  logic [31:0]        adr_i,
    input  logic [WB_DW-1:0]   dat_i,
    input  logic               ack_i
);

    localparam int LINE_WORDS = line_words(BUF_WIDTH);
    localparam int IDX_W      = (BUF_WIDTH > 0) ? BUF_WIDTH : 1;
    localparam int TAG_W      = ADDR_WIDTH - BUF_WIDTH - 2;
    localparam int CNT_W      = BUF_WIDTH + 1;

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[ADDR_WIDTH-1:BUF_WIDTH+2];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return IDX_W'((a >> 2) & 32'(LINE_WORDS - 1));
    endfunction

    port_state_e      state, state_d;
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [CNT_W-1:0] cnt;

    logic             req, wb_hit, wr_hit, fill_done;
    logic             buf_we;
    logic [IDX_W-1:0] buf_wr_idx, buf_rd_idx;
    logic [WB_SELW-1:0] buf_wr_sel;
    logic [WB_DW-1:0] buf_wr_dat, buf_rd_dat;

    // Handshakes: a WB request (cyc & stb) is accepted only in IDLE and completed by
    // a one-cycle wb_ack_o; acc_o is held from issue until ack_i (write) or until
    // every beat of the line has landed (read), and only issued while idle_i is high.
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wb_hit    = valid & (tag_of(wb_adr_i) == tag);
    assign wr_hit    = valid & (tag_of(adr_o) == tag);
    assign fill_done = (state == ST_FILL) & (cnt == CNT_W'(LINE_WORDS));

    assign wb_ack_o    = (state == ST_RESP) & wb_cyc_i & wb_stb_i;
    assign buf_width_o = 4'(BUF_WIDTH);

    logic unused_ok;
    assign unused_ok = ^{rdy_i, wb_adr_i, adr_i};

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (!wb_we_i && wb_hit) state_d = ST_RESP;
                    else if (idle_i)        state_d = wb_we_i ? ST_WRITE : ST_FILL;
                end
            end
            ST_FILL:  if (fill_done) state_d = ST_RESP;
            ST_WRITE: if (ack_i)     state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FILL indexes by the controller's beat address so any wrap order lands correctly.
    always_comb begin
        buf_we     = 1'b0;
        buf_wr_idx = idx_of(adr_i);
        buf_wr_sel = '1;
        buf_wr_dat = dat_i;
        if (state == ST_FILL) begin
            buf_we = ack_i & ~fill_done;
        end else if (state == ST_WRITE) begin
            buf_we     = ack_i & wr_hit;
            buf_wr_idx = idx_of(adr_o);
            buf_wr_sel = sel_o;
            buf_wr_dat = dat_o;
        end
    end

    assign buf_rd_idx = (state == ST_FILL) ? idx_of(adr_o) : idx_of(wb_adr_i);

    ddr_line_buf #(
        .BUF_WIDTH (BUF_WIDTH),
        .IDX_W     (IDX_W)
    ) u_line_buf (
        .clk    (local_clk_i),
        .wr_en  (buf_we),
        .wr_idx (buf_wr_idx),
        .wr_sel (buf_wr_sel),
        .wr_dat (buf_wr_dat),
        .rd_idx (buf_rd_idx),
        .rd_dat (buf_rd_dat)
    );

    always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
        if (!local_reset_n_i) state <= ST_IDLE;
        else                  state <= state_d;
    end

    always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
        if (!local_reset_n_i) begin
            acc_o    <= 1'b0;
            we_o     <= 1'b0;
            adr_o    <= '0;
            dat_o    <= '0;
            sel_o    <= '1;
            wb_dat_o <= '0;
            valid    <= 1'b0;
            tag      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (!wb_we_i && wb_hit) begin
                            wb_dat_o <= buf_rd_dat;
                        end else if (idle_i) begin
                            acc_o <= 1'b1;
                            adr_o <= wb_adr_i;
                            if (wb_we_i) begin
                                we_o  <= 1'b1;
                                dat_o <= wb_dat_i;
                                sel_o <= wb_sel_i;
                            end else begin
                                we_o  <= 1'b0;
                                sel_o <= '1;
                                valid <= 1'b0;
                                cnt   <= '0;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    if (fill_done) begin
                        acc_o    <= 1'b0;
                        valid    <= 1'b1;
                        tag      <= tag_of(adr_o);
                        wb_dat_o <= buf_rd_dat;
                    end else if (ack_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (ack_i) begin
                        acc_o <= 1'b0;
                        we_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ddr_rd_buf_port.sv
// Directed bench for wb_ddr_rd_buf_port with a behavioural DDR controller model.
module tb_wb_ddr_rd_buf_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        acc_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o, buf_width_o;
    logic        rdy_i = 1'b1;
    logic        idle_i = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // controller model observations
    logic [31:0] ddr_mem [0:255];
    int          beat_cnt;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we;
    logic        ack_i_q = 1'b0;

    always #5 clk = ~clk;

    wb_ddr_rd_buf_port #(.BUF_WIDTH(3), .ADDR_WIDTH(25)) dut (
        .local_clk_i     (clk),
        .local_reset_n_i (rst_n),
        .wb_adr_i        (wb_adr),
        .wb_dat_i        (wb_dat),
        .wb_sel_i        (wb_sel),
        .wb_we_i         (wb_we),
        .wb_cyc_i        (wb_cyc),
        .wb_stb_i        (wb_stb),
        .wb_dat_o        (wb_dat_o),
        .wb_ack_o        (wb_ack_o),
        .acc_o           (acc_o),
        .we_o            (we_o),
        .adr_o           (adr_o),
        .dat_o           (dat_o),
        .sel_o           (sel_o),
        .buf_width_o     (buf_width_o),
        .rdy_i           (rdy_i),
        .idle_i          (idle_i),
        .adr_i           (adr_i),
        .dat_i           (dat_i),
        .ack_i           (ack_i)
    );

    always @(posedge clk) ack_i_q <= ack_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // DDR controller model: 8-beat wrapping read bursts, single-beat writes.
    initial begin
        logic [31:0] base;
        int          start, guard;
        for (int i = 0; i < 256; i++) ddr_mem[i] = 32'hC000_0000 | (i << 2);
        for (int k = 0; k < 8; k++) ddr_mem[(32'h100 >> 2) + k] = 32'hA0 + k;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_i  = 1'b0;
                idle_i = 1'b1;
            end else if (acc_o && idle_i) begin
                idle_i = 1'b0;
                m_adr = adr_o; m_we = we_o; m_sel = sel_o; m_dat = dat_o;
                if (we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (sel_o[b]) ddr_mem[adr_o[9:2]][8*b +: 8] = dat_o[8*b +: 8];
                    ack_i = 1'b1;
                    @(negedge clk);
                    ack_i = 1'b0;
                end else begin
                    base  = adr_o & ~32'h1F;
                    start = int'(adr_o[4:2]);
                    for (int k = 0; k < 8; k++) begin
                        if (!rst_n) break;
                        adr_i = base + 32'(((start + k) & 7) * 4);
                        dat_i = ddr_mem[adr_i[9:2]];
                        ack_i = 1'b1;
                        beat_cnt++;
                        @(negedge clk);
                    end
                    ack_i = 1'b0;
                end
                guard = 0;
                while (acc_o && rst_n && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                idle_i = 1'b1;
            end
        end
    end

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data,
                           output int lat, output logic acc_seen);
        beat_cnt = 0;
        @(negedge clk);
        wb_adr = addr; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 0; acc_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (acc_o) acc_seen = 1'b1;
        end while (!wb_ack_o && lat < 100);
        data = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data,
                            output int lat, output logic acki_before);
        @(negedge clk);
        wb_adr = addr; wb_we = 1'b1; wb_sel = sel; wb_dat = data; wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack_o && lat < 100);
        acki_before = ack_i_q;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat, guard, acks;
        logic        accs, ab;

        // reset values
        repeat (3) @(negedge clk);
        check_eq("rst_acc", acc_o, 0);
        check_eq("rst_we", we_o, 0);
        check_eq("rst_ack", wb_ack_o, 0);
        check_eq("rst_adr", adr_o, 0);
        check_eq("rst_dat", dat_o, 0);
        check_eq("rst_wbdat", wb_dat_o, 0);
        check_eq("rst_sel", sel_o, 4'hF);
        check_eq("buf_width", buf_width_o, 3);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // read miss with wrapping burst
        wb_read(32'h108, rd, lat, accs);
        check_eq("miss_data", rd, 32'hA2);
        check_eq("miss_lat", lat, 10);
        check_eq("miss_acc", accs, 1);
        check_eq("miss_beats", beat_cnt, 8);
        check_eq("miss_req_we", m_we, 0);
        check_eq("miss_req_adr", m_adr, 32'h108);
        check_eq("miss_req_sel", m_sel, 4'hF);
        @(negedge clk);
        check_eq("miss_ack_single", wb_ack_o, 0);

        // read hit
        wb_read(32'h11C, rd, lat, accs);
        check_eq("hit_data", rd, 32'hA7);
        check_eq("hit_lat", lat, 1);
        check_eq("hit_acc", accs, 0);

        // write merge into the buffered line
        wb_write(32'h104, 4'b0011, 32'h1234_5678, lat, ab);
        check_eq("wr_lat", lat, 2);
        check_eq("wr_ack_after_acki", ab, 1);
        check_eq("wr_req_we", m_we, 1);
        check_eq("wr_req_adr", m_adr, 32'h104);
        check_eq("wr_req_sel", m_sel, 4'b0011);
        check_eq("wr_req_dat", m_dat, 32'h1234_5678);
        wb_read(32'h104, rd, lat, accs);
        check_eq("merge_data", rd, 32'h0000_5678);
        check_eq("merge_hit", accs, 0);

        // write outside the line
        wb_write(32'h200, 4'hF, 32'hCAFE_F00D, lat, ab);
        check_eq("wr2_adr", m_adr, 32'h200);
        wb_read(32'h100, rd, lat, accs);
        check_eq("outside_data", rd, 32'hA0);
        check_eq("outside_hit", accs, 0);

        // reset during FILL
        beat_cnt = 0;
        @(negedge clk);
        wb_adr = 32'h308; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        guard = 0;
        while (beat_cnt < 3 && guard < 50) begin @(negedge clk); guard++; end
        check_eq("rstfill_reached", guard < 50, 1);
        rst_n = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        check_eq("rstfill_acc", acc_o, 0);
        check_eq("rstfill_ack", wb_ack_o, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wb_read(32'h308, rd, lat, accs);
        check_eq("rstfill_remiss", accs, 1);
        check_eq("rstfill_data", rd, 32'hC000_0308);

        // cyc dropped during FILL
        beat_cnt = 0;
        @(negedge clk);
        wb_adr = 32'h110; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        guard = 0;
        while (beat_cnt < 3 && guard < 50) begin @(negedge clk); guard++; end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_ack_o) acks++;
        end
        check_eq("abort_beats", beat_cnt, 8);
        check_eq("abort_no_ack", acks, 0);
        wb_read(32'h110, rd, lat, accs);
        check_eq("abort_hit_data", rd, 32'hA4);
        check_eq("abort_hit", accs, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
